serial_frame_deserializer: RTL and testbench

- Receive end of the team's serial bit-stream path: recovers framed words from a 1-bit line and presents them as parallel words on a valid/ready output.
- Pairs with the serializing side of the same link.
- Sits between a shift-register/serializer source and a parallel consumer such as a FIFO or register bank.

---
 rtl/serial_frame_deserializer.sv | 137 +++++++++++++
 tb/tb_serial_frame_deserializer.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/serial_frame_deserializer.sv
// Serial frame deserializer: recovers start/data/stop framed words from a
// 1-bit line sampled on s_en strobes and presents them on a valid/ready port.
//
// Output handshake: m_valid means m_data holds an unconsumed word; the word
// transfers on any rising edge where m_valid && m_ready. A new word may load
// on the same edge as a transfer, in which case m_valid stays high.
module serial_frame_deserializer #(
    parameter int DATA_W    = 8,
    parameter bit LSB_FIRST = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              s_in,
    input  logic              s_en,
    output logic [DATA_W-1:0] m_data,
    output logic              m_valid,
    input  logic              m_ready,
    output logic              frame_err,
    output logic              overrun
);

    localparam int CNT_W = (DATA_W > 2) ? $clog2(DATA_W) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W - 1);

    // WAIT_HI holds off new start bits after a bad stop until the line is
    // seen high, so a low stop bit is never mistaken for a start bit.
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        DATA    = 2'd1,
        STOP    = 2'd2,
        WAIT_HI = 2'd3
    } state_t;

    state_t             state;
    state_t             state_nxt;
    logic [CNT_W-1:0]   cnt;
    logic [CNT_W-1:0]   cnt_nxt;
    logic [DATA_W-1:0]  sr;
    logic [DATA_W-1:0]  sr_nxt;
    logic               load;
    logic               drop;
    logic               bad_stop;

    // Next-state, bit counter, shift register and frame-completion decode.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        sr_nxt    = sr;
        load      = 1'b0;
        drop      = 1'b0;
        bad_stop  = 1'b0;
        if (s_en) begin
            case (state)
                IDLE: begin
                    if (!s_in) begin
                        state_nxt = DATA;
                        cnt_nxt   = '0;
                    end
                end
                DATA: begin
                    if (LSB_FIRST) begin
                        sr_nxt = {s_in, sr[DATA_W-1:1]};
                    end else begin
                        sr_nxt = {sr[DATA_W-2:0], s_in};
                    end
                    if (cnt == CNT_LAST) begin
                        cnt_nxt   = '0;
                        state_nxt = STOP;
                    end else begin
                        cnt_nxt = cnt + 1'b1;
                    end
                end
                STOP: begin
                    if (s_in) begin
                        state_nxt = IDLE;
                        if (!m_valid || m_ready) begin
                            load = 1'b1;
                        end else begin
                            drop = 1'b1;
                        end
                    end else begin
                        state_nxt = WAIT_HI;
                        bad_stop  = 1'b1;
                    end
                end
                WAIT_HI: begin
                    if (s_in) begin
                        state_nxt = IDLE;
                    end
                end
                default: begin
                    state_nxt = IDLE;
                end
            endcase
        end
    end

    // Receiver state register, counter and shift register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
            sr    <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            sr    <= sr_nxt;
        end
    end

    // Output word register and valid flag; a load wins over a transfer.
    always_ff @(posedge clk) begin
        if (rst) begin
            m_data  <= '0;
            m_valid <= 1'b0;
        end else if (load) begin
            m_data  <= sr;
            m_valid <= 1'b1;
        end else if (m_valid && m_ready) begin
            m_valid <= 1'b0;
        end
    end

    // Status: one-cycle frame error pulse and sticky overrun flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            frame_err <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            frame_err <= bad_stop;
            if (drop) begin
                overrun <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_serial_frame_deserializer.sv
// Directed testbench for serial_frame_deserializer: one LSB-first and one
// MSB-first instance share the serial line, strobe, reset and ready.
module tb_serial_frame_deserializer;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       s_in = 1'b1;
    logic       s_en = 1'b0;
    logic       m_ready = 1'b1;

    logic [7:0] m_data_a;
    logic       m_valid_a;
    logic       frame_err_a;
    logic       overrun_a;

    logic [7:0] m_data_b;
    logic       m_valid_b;
    logic       frame_err_b;
    logic       overrun_b;

    int total = 0;
    int bad   = 0;
    int gap   = 0;

    // clock / reset block
    always #5 clk = ~clk;

    serial_frame_deserializer #(.DATA_W(8), .LSB_FIRST(1'b1)) dut (
        .clk       (clk),
        .rst       (rst),
        .s_in      (s_in),
        .s_en      (s_en),
        .m_data    (m_data_a),
        .m_valid   (m_valid_a),
        .m_ready   (m_ready),
        .frame_err (frame_err_a),
        .overrun   (overrun_a)
    );

    serial_frame_deserializer #(.DATA_W(8), .LSB_FIRST(1'b0)) dut_msb (
        .clk       (clk),
        .rst       (rst),
        .s_in      (s_in),
        .s_en      (s_en),
        .m_data    (m_data_b),
        .m_valid   (m_valid_b),
        .m_ready   (m_ready),
        .frame_err (frame_err_b),
        .overrun   (overrun_b)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    task automatic do_reset();
        s_en = 1'b0;
        s_in = 1'b1;
        rst  = 1'b1;
        @(posedge clk);
        #1;
        rst  = 1'b0;
    endtask

    // Idle gap cycles with a toggled (unsampled) line, then one strobed bit.
    task automatic strobe(input logic b);
        repeat (gap) begin
            s_en = 1'b0;
            s_in = ~b;
            @(posedge clk);
            #1;
        end
        s_in = b;
        s_en = 1'b1;
        @(posedge clk);
        #1;
        s_en = 1'b0;
        s_in = 1'b1;
    endtask

    // Start bit plus eight data bits; the stop bit is sent separately.
    task automatic send_word(input logic [7:0] d, input bit lsb);
        strobe(1'b0);
        for (int i = 0; i < 8; i++) begin
            strobe(lsb ? d[i] : d[7-i]);
        end
    endtask

    initial begin
        // reset state
        @(posedge clk);
        #1;
        do_reset();
        chk("rst_data", 32'(m_data_a), 32'h00);
        chk("rst_valid", 32'(m_valid_a), 32'h0);
        chk("rst_ferr", 32'(frame_err_a), 32'h0);
        chk("rst_ovr", 32'(overrun_a), 32'h0);

        // byte receive, LSB first, strobe every cycle
        gap = 0;
        m_ready = 1'b1;
        send_word(8'hA5, 1'b1);
        chk("t1_no_early_valid", 32'(m_valid_a), 32'h0);
        strobe(1'b1);
        chk("t1_valid", 32'(m_valid_a), 32'h1);
        chk("t1_data", 32'(m_data_a), 32'hA5);
        chk("t1_ferr", 32'(frame_err_a), 32'h0);
        @(posedge clk);
        #1;
        chk("t1_valid_drop", 32'(m_valid_a), 32'h0);
        chk("t1_ovr", 32'(overrun_a), 32'h0);

        // MSB first with a strobe every third cycle
        do_reset();
        gap = 2;
        send_word(8'h3C, 1'b0);
        chk("t2_no_early_valid", 32'(m_valid_b), 32'h0);
        strobe(1'b1);
        chk("t2_valid", 32'(m_valid_b), 32'h1);
        chk("t2_data", 32'(m_data_b), 32'h3C);
        gap = 0;

        // framing error, held-low line, then a clean frame
        do_reset();
        send_word(8'h5A, 1'b1);
        strobe(1'b0);
        chk("t3_ferr_pulse", 32'(frame_err_a), 32'h1);
        chk("t3_no_valid", 32'(m_valid_a), 32'h0);
        strobe(1'b0);
        chk("t3_ferr_once", 32'(frame_err_a), 32'h0);
        strobe(1'b0);
        chk("t3_ferr_low2", 32'(frame_err_a), 32'h0);
        strobe(1'b1);
        send_word(8'h81, 1'b1);
        strobe(1'b1);
        chk("t3_valid", 32'(m_valid_a), 32'h1);
        chk("t3_data", 32'(m_data_a), 32'h81);
        chk("t3_ferr_clean", 32'(frame_err_a), 32'h0);

        // simultaneous consume and load
        do_reset();
        m_ready = 1'b0;
        send_word(8'h33, 1'b1);
        strobe(1'b1);
        chk("t5_hold_data", 32'(m_data_a), 32'h33);
        send_word(8'h44, 1'b1);
        chk("t5_hold_valid", 32'(m_valid_a), 32'h1);
        m_ready = 1'b1;
        strobe(1'b1);
        chk("t5_valid", 32'(m_valid_a), 32'h1);
        chk("t5_data", 32'(m_data_a), 32'h44);
        chk("t5_ovr", 32'(overrun_a), 32'h0);
        @(posedge clk);
        #1;
        chk("t5_valid_drop", 32'(m_valid_a), 32'h0);

        // overrun and back-to-back frames
        do_reset();
        m_ready = 1'b0;
        send_word(8'h11, 1'b1);
        strobe(1'b1);
        chk("t4_first_valid", 32'(m_valid_a), 32'h1);
        chk("t4_first_data", 32'(m_data_a), 32'h11);
        chk("t4_no_ovr_yet", 32'(overrun_a), 32'h0);
        send_word(8'h22, 1'b1);
        strobe(1'b1);
        chk("t4_data_held", 32'(m_data_a), 32'h11);
        chk("t4_ovr", 32'(overrun_a), 32'h1);
        m_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("t4_accept", 32'(m_valid_a), 32'h0);
        chk("t4_data_after", 32'(m_data_a), 32'h11);
        repeat (3) @(posedge clk);
        #1;
        chk("t4_ovr_sticky", 32'(overrun_a), 32'h1);

        // reset mid-frame
        strobe(1'b0);
        for (int i = 0; i < 4; i++) begin
            strobe(1'b1);
        end
        do_reset();
        chk("t6_rst_data", 32'(m_data_a), 32'h00);
        chk("t6_rst_valid", 32'(m_valid_a), 32'h0);
        chk("t6_rst_ovr", 32'(overrun_a), 32'h0);
        chk("t6_rst_ferr", 32'(frame_err_a), 32'h0);
        send_word(8'h0F, 1'b1);
        strobe(1'b1);
        chk("t6_valid", 32'(m_valid_a), 32'h1);
        chk("t6_data", 32'(m_data_a), 32'h0F);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
